// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: pipeline-side signals of the hazard unit, driven by the pipeline (master)
// and consumed by the hazard unit (slave).
interface hazard_ctrl_unit_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0]    rs1D_i, rs2D_i, rdD_i;
  logic                     reg_writeD_i, mc_opD_i;
  logic [ADDR_WIDTH-1:0]    rs1E_i, rs2E_i, rdE_i;
  logic                     mem_readE_i, mc_issueE_i, branch_takenE_i;
  logic [ADDR_WIDTH-1:0]    rdM_i, rdW_i, mc_wb_rd_i;
  logic                     reg_writeM_i, reg_writeW_i, mc_wb_i;
  logic [1:0]               forward_aE_o, forward_bE_o;
  logic                     stall_f_o, stall_d_o, flush_d_o, flush_e_o;
  logic [2**ADDR_WIDTH-1:0] sb_busy_o;
  logic [CNT_WIDTH-1:0]     stall_cnt_o;
  modport master (
    output rs1D_i, rs2D_i, rdD_i, reg_writeD_i, mc_opD_i, rs1E_i, rs2E_i, rdE_i,
           mem_readE_i, mc_issueE_i, branch_takenE_i, rdM_i, reg_writeM_i,
           rdW_i, reg_writeW_i, mc_wb_i, mc_wb_rd_i,
    input  forward_aE_o, forward_bE_o, stall_f_o, stall_d_o, flush_d_o, flush_e_o,
           sb_busy_o, stall_cnt_o
  );
  modport slave (
    input  rs1D_i, rs2D_i, rdD_i, reg_writeD_i, mc_opD_i, rs1E_i, rs2E_i, rdE_i,
           mem_readE_i, mc_issueE_i, branch_takenE_i, rdM_i, reg_writeM_i,
           rdW_i, reg_writeW_i, mc_wb_i, mc_wb_rd_i,
    output forward_aE_o, forward_bE_o, stall_f_o, stall_d_o, flush_d_o, flush_e_o,
           sb_busy_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: EX operand forwarding, load-use/scoreboard/capacity stalls, branch flush,
// multi-cycle register scoreboard and stall-cycle counter.
module hazard_ctrl_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int MC_DEPTH   = 2,
  parameter int CNT_WIDTH  = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  hazard_ctrl_unit_if.slave bus
);
  localparam int NREG = 2**ADDR_WIDTH;
  logic [NREG-1:0]      busy_q, busy_d;
  logic [2:0]           out_q, out_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 lu, sb, cap, stall;
  always_comb begin
    bus.forward_aE_o = (bus.reg_writeM_i && bus.rs1E_i != '0 && bus.rdM_i == bus.rs1E_i) ? 2'b10 :
                       (bus.reg_writeW_i && bus.rs1E_i != '0 && bus.rdW_i == bus.rs1E_i) ? 2'b01 : 2'b00;
    bus.forward_bE_o = (bus.reg_writeM_i && bus.rs2E_i != '0 && bus.rdM_i == bus.rs2E_i) ? 2'b10 :
                       (bus.reg_writeW_i && bus.rs2E_i != '0 && bus.rdW_i == bus.rs2E_i) ? 2'b01 : 2'b00;
    lu    = bus.mem_readE_i && bus.rdE_i != '0 && (bus.rdE_i == bus.rs1D_i || bus.rdE_i == bus.rs2D_i);
    sb    = busy_q[bus.rs1D_i] || busy_q[bus.rs2D_i] || (bus.reg_writeD_i && busy_q[bus.rdD_i]);
    cap   = bus.mc_opD_i && (({1'b0, out_q} + {3'b000, bus.mc_issueE_i}) >= 4'(MC_DEPTH));
    stall = lu || sb || cap;
    bus.stall_f_o   = stall && !bus.branch_takenE_i;
    bus.stall_d_o   = stall && !bus.branch_takenE_i;
    bus.flush_d_o   = bus.branch_takenE_i;
    bus.flush_e_o   = stall || bus.branch_takenE_i;
    bus.sb_busy_o   = busy_q;
    bus.stall_cnt_o = cnt_q;
  end
  // Clear before set so a same-cycle retire/issue to one register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (bus.mc_wb_i) busy_d[bus.mc_wb_rd_i] = 1'b0;
    if (bus.mc_issueE_i && bus.rdE_i != '0) busy_d[bus.rdE_i] = 1'b1;
    out_d = (bus.mc_issueE_i && !bus.mc_wb_i) ? ((out_q == 3'(MC_DEPTH)) ? out_q : out_q + 3'd1) :
            (bus.mc_wb_i && !bus.mc_issueE_i) ? ((out_q == 3'd0) ? out_q : out_q - 3'd1) : out_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      out_q  <= out_d;
      cnt_q  <= bus.stall_f_o ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed plus random stimulus; expected outputs come from a
// register-array model and are queued for a negedge monitor.
module tb_hazard_ctrl_unit;
  localparam int AW = 5, MCD = 2, CW = 32, NR = 2**AW;
  typedef struct {
    logic [AW-1:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM, rdW, wbrd;
    logic wD, mcD, memE, issue, br, wM, wW, wb;
  } stim_t;
  typedef struct {
    logic [1:0] fa, fb;
    logic sf, sd, fd, fe;
    logic [NR-1:0] busy;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 0, rst_n = 0;
  hazard_ctrl_unit_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  hazard_ctrl_unit #(.ADDR_WIDTH(AW), .MC_DEPTH(MCD), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;

  exp_t q[$];
  int errors = 0, checks = 0;
  bit m_busy[NR];
  int m_out;
  logic [CW-1:0] m_cnt;
  bit m_sf;
  stim_t cur;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (q.size() > 0) begin
    exp_t e;
    e = q.pop_front();
    chk("forward_aE", 64'(bus.forward_aE_o), 64'(e.fa));
    chk("forward_bE", 64'(bus.forward_bE_o), 64'(e.fb));
    chk("stall_f", 64'(bus.stall_f_o), 64'(e.sf));
    chk("stall_d", 64'(bus.stall_d_o), 64'(e.sd));
    chk("flush_d", 64'(bus.flush_d_o), 64'(e.fd));
    chk("flush_e", 64'(bus.flush_e_o), 64'(e.fe));
    chk("sb_busy", 64'(bus.sb_busy_o), 64'(e.busy));
    chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(e.cnt));
  end

  function automatic logic [1:0] fwd(logic [AW-1:0] rs, stim_t s);
    if (rs == 0) return 2'b00;
    if (s.wM && s.rdM == rs) return 2'b10;
    if (s.wW && s.rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_out = 0;
    m_cnt = '0;
    m_sf = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_sf) m_cnt = m_cnt + 1'b1;
    if (cur.issue && !cur.wb) m_out = (m_out < MCD) ? m_out + 1 : MCD;
    if (cur.wb && !cur.issue) m_out = (m_out > 0) ? m_out - 1 : 0;
    if (cur.wb) m_busy[cur.wbrd] = 0;
    if (cur.issue && cur.rdE != 0) m_busy[cur.rdE] = 1;
  endtask

  task automatic apply(stim_t s);
    bus.rs1D_i = s.rs1D; bus.rs2D_i = s.rs2D; bus.rdD_i = s.rdD;
    bus.reg_writeD_i = s.wD; bus.mc_opD_i = s.mcD;
    bus.rs1E_i = s.rs1E; bus.rs2E_i = s.rs2E; bus.rdE_i = s.rdE;
    bus.mem_readE_i = s.memE; bus.mc_issueE_i = s.issue; bus.branch_takenE_i = s.br;
    bus.rdM_i = s.rdM; bus.reg_writeM_i = s.wM; bus.rdW_i = s.rdW; bus.reg_writeW_i = s.wW;
    bus.mc_wb_i = s.wb; bus.mc_wb_rd_i = s.wbrd;
  endtask

  task automatic step(stim_t s, bit rst_v = 1);
    exp_t e;
    bit lu, sb, cap, st;
    @(posedge clk);
    model_edge();
    #1;
    rst_n = rst_v;
    if (!rst_v) model_reset();
    cur = s;
    apply(s);
    lu  = s.memE && s.rdE != 0 && (s.rdE == s.rs1D || s.rdE == s.rs2D);
    sb  = m_busy[s.rs1D] || m_busy[s.rs2D] || (s.wD && m_busy[s.rdD]);
    cap = s.mcD && (m_out + int'(s.issue) >= MCD);
    st  = lu || sb || cap;
    e.fa = fwd(s.rs1E, s);
    e.fb = fwd(s.rs2E, s);
    e.sf = st && !s.br;
    e.sd = st && !s.br;
    e.fd = s.br;
    e.fe = st || s.br;
    foreach (m_busy[i]) e.busy[i] = m_busy[i];
    e.cnt = m_cnt;
    m_sf = e.sf;
    q.push_back(e);
  endtask

  initial begin
    stim_t z, s;
    z = '{default: 0};
    cur = z;
    apply(z);
    model_reset();
    step(z, 0);
    step(z, 0);
    step(z);
    s = z; s.rs1E = 5; s.rdM = 5; s.rdW = 5; s.wM = 1; s.wW = 1; step(s);
    s.rs2E = 0; s.rdM = 0; step(s);
    s = z; s.rdM = 7; s.rdW = 6; s.wM = 1; s.wW = 1; s.rs2E = 6; s.rs1E = 7; step(s);
    s = z; s.memE = 1; s.rdE = 3; s.rs2D = 3; step(s);
    step(z);
    step(z);
    s = z; s.issue = 1; s.rdE = 9; step(s);
    s = z; s.rs1D = 9;
    repeat (3) step(s);
    s.wb = 1; s.wbrd = 9; step(s);
    s = z; s.rs1D = 9; step(s);
    s = z; s.issue = 1; s.rdE = 4; step(s);
    s = z; s.issue = 1; s.rdE = 4; s.wb = 1; s.wbrd = 4; step(s);
    s = z; s.mcD = 1; s.issue = 1; s.rdE = 10; step(s);
    s = z; s.mcD = 1; step(s);
    s = z; s.wD = 1; s.rdD = 10; step(s);
    s = z; s.memE = 1; s.rdE = 2; s.rs1D = 2; s.br = 1; s.mcD = 1; step(s);
    s = z; s.memE = 1; s.rdE = 2; s.rs1D = 2;
    while (m_cnt < 17) step(s);
    s = z; s.mcD = 1; step(s, 0);
    step(z, 0);
    step(z);
    for (int n = 0; n < 400; n++) begin
      s.rs1D = AW'($urandom_range(0, 7)); s.rs2D = AW'($urandom_range(0, 7));
      s.rdD = AW'($urandom_range(0, 7)); s.rs1E = AW'($urandom_range(0, 7));
      s.rs2E = AW'($urandom_range(0, 7)); s.rdE = AW'($urandom_range(0, 7));
      s.rdM = AW'($urandom_range(0, 7)); s.rdW = AW'($urandom_range(0, 7));
      s.wbrd = AW'($urandom_range(0, 7));
      s.wD = $urandom_range(0, 1) == 0; s.mcD = $urandom_range(0, 2) == 0;
      s.memE = $urandom_range(0, 2) == 0; s.issue = $urandom_range(0, 3) == 0;
      s.br = $urandom_range(0, 7) == 0; s.wM = $urandom_range(0, 1) == 0;
      s.wW = $urandom_range(0, 1) == 0; s.wb = $urandom_range(0, 3) == 0;
      step(s, $urandom_range(0, 99) != 0);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Second-generation data and control hazard unit for the 5-stage pipeline. It selects operand forwarding for the execute stage from the M and W stages. It detects load-use hazards, flushes on taken branches, and keeps a register scoreboard for writes from the multi-cycle unit (divider/multiplier), so decode stalls until an outstanding result has been written back. It also provides a stall-cycle performance counter.

Parameters:
ADDR_WIDTH, 5, register address width; register file has 2**ADDR_WIDTH entries.
MC_DEPTH, 2, maximum outstanding multi-cycle operations (1..7).
CNT_WIDTH, 32, stall performance counter width.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  reset, asynchronous, active-low
rs1D_i  in  ADDR_WIDTH  source reg 1 (decode)
rs2D_i  in  ADDR_WIDTH  source reg 2 (decode)
rdD_i  in  ADDR_WIDTH  destination reg (decode)
reg_writeD_i  in  1  decode instruction writes rd
mc_opD_i  in  1  decode instruction is a multi-cycle op
rs1E_i  in  ADDR_WIDTH  source reg 1 (execute)
rs2E_i  in  ADDR_WIDTH  source reg 2 (execute)
rdE_i  in  ADDR_WIDTH  destination reg (execute)
mem_readE_i  in  1  execute instruction is a load
mc_issueE_i  in  1  multi-cycle op issued from execute this cycle (uses rdE_i)
branch_takenE_i  in  1  branch/jump resolved taken in execute
rdM_i  in  ADDR_WIDTH  destination reg (memory)
reg_writeM_i  in  1  write enable (memory)
rdW_i  in  ADDR_WIDTH  destination reg (writeback)
reg_writeW_i  in  1  write enable (writeback)
mc_wb_i  in  1  multi-cycle result written back this cycle
mc_wb_rd_i  in  ADDR_WIDTH  register written by mc_wb_i
forward_aE_o  out  2  rs1E select: 00 regfile, 01 W, 10 M
forward_bE_o  out  2  rs2E select, same encoding
stall_f_o  out  1  hold PC
stall_d_o  out  1  hold IF/ID register
flush_d_o  out  1  clear IF/ID register
flush_e_o  out  1  clear ID/EX register (insert bubble)
sb_busy_o  out  2**ADDR_WIDTH  scoreboard pending-write bits
stall_cnt_o  out  CNT_WIDTH  count of stalled cycles

Behaviour:
- Forwarding (combinational): M match has priority over W match. A match needs equal address, the matching stage's write enable, and a non-zero source. Otherwise the select is 00.
- Load-use hazard: lu = mem_readE_i & rdE_i!=0 & (rdE_i==rs1D_i | rdE_i==rs2D_i).
- Scoreboard hazard: sb = busy[rs1D_i] | busy[rs2D_i] (RAW) | (reg_writeD_i & busy[rdD_i]) (WAW). Register 0 is never busy.
- Capacity hazard: cap = mc_opD_i & (outstanding + mc_issueE_i) >= MC_DEPTH. The count is taken before the current cycle's retirement.
- stall = lu | sb | cap. The outputs are stall_f_o = stall_d_o = flush_e_o = stall, unless a branch is taken.
- Branch taken dominates: flush_d_o = flush_e_o = 1 and stall_f_o = stall_d_o = 0, regardless of any hazard.
- Scoreboard update per clock: clear busy[mc_wb_rd_i] if mc_wb_i, then set busy[rdE_i] if mc_issueE_i & rdE_i != 0. If both target the same register, set wins and the bit stays 1.
- Outstanding counter, 3-bit: increments on mc_issueE_i and decrements on mc_wb_i. Both together leave it unchanged.
- Retirement with outstanding==0 is a protocol error. The counter saturates at 0 and sb_busy_o is unchanged except for the clear.
- Issue when outstanding==MC_DEPTH saturates at MC_DEPTH; decode's cap stall prevents this in legal use.
- A register already busy does not block forwarding of an unrelated M/W write. Forwarding never sources the multi-cycle unit; consumers wait on the scoreboard.
- stall_cnt_o increments on every cycle with stall_f_o=1 and wraps modulo 2**CNT_WIDTH.
- Reset (rst_ni low, any time, including mid-operation): busy all 0, outstanding 0, stall_cnt_o 0.
- During reset the combinational outputs still follow their inputs with an empty scoreboard.
- Latency: scoreboard set/clear is visible to the hazard logic on the cycle after the edge. A value written back by mc_wb_i at edge N is read via the W forward path or the regfile; busy drops from cycle N+1.

Test Plan:
- Forwarding: rs1E=5, rdM=5, rdW=5, both write enables 1 -> forward_aE=10. Set rs2E=0, rdM=0 -> forward_bE=00. rdM=7, rdW=6, rs2E=6 -> forward_bE=01.
- Load-use: mem_readE=1, rdE=3, rs2D=3 for one cycle -> stall_f=stall_d=flush_e=1, stall_cnt increments by 1. The next cycle with mem_readE=0 -> all 0.
- Scoreboard RAW: mc_issueE with rdE=9, then rs1D=9 -> stall held until mc_wb with rd=9. busy[9] falls the cycle after the writeback edge, then stall=0.
- Same-cycle writeback/issue to reg 4 -> busy[4] stays 1, outstanding unchanged. Capacity: MC_DEPTH=2 with 2 outstanding and mc_opD=1 -> stall.
- Branch priority: lu active and branch_takenE=1 -> flush_d=flush_e=1, stall_f=stall_d=0.
- Async reset: with 2 busy registers and stall_cnt=17, pull rst_ni low mid-cycle -> sb_busy_o=0 and stall_cnt_o=0 immediately, before the next clock edge.
